// File: rtl/mips_hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// Shadows destination/Tnew/load info through E, M, W and drives stall and forwarding selects.
module mips_hazard_fwd_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs_d,
  input  logic [1:0] tuse_rt_d,
  input  logic [4:0] a3_d,
  input  logic [1:0] tnew_d,
  input  logic       ld_d,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic [1:0] ForwardRTM
);

  logic [4:0] e_a3_q, e_a3_d;
  logic [1:0] e_tnew_q, e_tnew_d;
  logic       e_ld_q, e_ld_d;
  logic [4:0] e_rs_q, e_rs_d;
  logic [4:0] e_rt_q, e_rt_d;
  logic [4:0] m_a3_q, m_a3_d;
  logic [1:0] m_tnew_q, m_tnew_d;
  logic       m_ld_q, m_ld_d;
  logic [4:0] m_rt_q, m_rt_d;
  logic [4:0] w_a3_q, w_a3_d;
  logic       w_ld_q, w_ld_d;

  // No E->D path exists, so an E producer always needs at least one cycle.
  function automatic logic op_stall(input logic [4:0] r, input logic [1:0] tuse,
                                    input logic [4:0] ea3, input logic [1:0] etnew,
                                    input logic [4:0] ma3, input logic [1:0] mtnew);
    logic [1:0] e_need;
    e_need   = (etnew == 2'd0) ? 2'd1 : etnew;
    op_stall = (tuse != 2'd3) && (r != 5'd0) &&
               (((ea3 == r) && (tuse < e_need)) || ((ma3 == r) && (tuse < mtnew)));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic [4:0] ma3,
                                         input logic [1:0] mtnew, input logic [4:0] wa3);
    if ((r != 5'd0) && (ma3 == r) && (mtnew == 2'd0)) fwd_sel = 2'b01;
    else if ((r != 5'd0) && (wa3 == r))               fwd_sel = 2'b10;
    else                                              fwd_sel = 2'b00;
  endfunction

  always_comb begin
    stall = op_stall(rs_d, tuse_rs_d, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q) |
            op_stall(rt_d, tuse_rt_d, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q);
    fwd_rs_d = fwd_sel(rs_d,   m_a3_q, m_tnew_q, w_a3_q);
    fwd_rt_d = fwd_sel(rt_d,   m_a3_q, m_tnew_q, w_a3_q);
    fwd_rs_e = fwd_sel(e_rs_q, m_a3_q, m_tnew_q, w_a3_q);
    fwd_rt_e = fwd_sel(e_rt_q, m_a3_q, m_tnew_q, w_a3_q);
    ForwardRTM = 2'b00;
    if ((m_rt_q != 5'd0) && (w_a3_q == m_rt_q))
      ForwardRTM = w_ld_q ? 2'b10 : 2'b01;
  end

  always_comb begin
    e_a3_d   = '0;
    e_tnew_d = '0;
    e_ld_d   = 1'b0;
    e_rs_d   = '0;
    e_rt_d   = '0;
    if (!stall) begin
      e_a3_d   = a3_d;
      e_tnew_d = tnew_d;
      e_ld_d   = ld_d;
      e_rs_d   = rs_d;
      e_rt_d   = rt_d;
    end
    m_a3_d   = e_a3_q;
    m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    m_ld_d   = e_ld_q;
    m_rt_d   = e_rt_q;
    w_a3_d   = m_a3_q;
    w_ld_d   = m_ld_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_a3_q   <= '0;
      e_tnew_q <= '0;
      e_ld_q   <= 1'b0;
      e_rs_q   <= '0;
      e_rt_q   <= '0;
      m_a3_q   <= '0;
      m_tnew_q <= '0;
      m_ld_q   <= 1'b0;
      m_rt_q   <= '0;
      w_a3_q   <= '0;
      w_ld_q   <= 1'b0;
    end else begin
      e_a3_q   <= e_a3_d;
      e_tnew_q <= e_tnew_d;
      e_ld_q   <= e_ld_d;
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      m_a3_q   <= m_a3_d;
      m_tnew_q <= m_tnew_d;
      m_ld_q   <= m_ld_d;
      m_rt_q   <= m_rt_d;
      w_a3_q   <= w_a3_d;
      w_ld_q   <= w_ld_d;
    end
  end

endmodule

// File: tb/tb_mips_hazard_fwd_ctrl.sv
// Self-checking bench for mips_hazard_fwd_ctrl: directed scenarios plus random traffic
// against an instruction-age reference model.
module tb_mips_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, a3_d;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
  logic       ld_d;
  logic       stall;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, ForwardRTM;

  always #5 clk = ~clk;

  mips_hazard_fwd_ctrl dut (
    .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
    .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d), .a3_d(a3_d),
    .tnew_d(tnew_d), .ld_d(ld_d), .stall(stall),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
    .fwd_rt_e(fwd_rt_e), .ForwardRTM(ForwardRTM)
  );

  // Model: in-flight instructions indexed by age since entering E (0=E, 1=M, 2=W).
  typedef struct {
    logic [4:0] a3;
    logic [4:0] rs;
    logic [4:0] rt;
    int         tnew;
    bit         ld;
  } ent_t;

  ent_t pipe[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [10:0] obs, exp_v;

  function automatic int remaining(int age);
    int t;
    t = pipe[age].tnew - age;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic bit m_stall_op(logic [4:0] r, int tuse);
    int need_e;
    if (tuse == 3 || r == 0) return 0;
    need_e = (remaining(0) > 1) ? remaining(0) : 1;
    if (pipe[0].a3 == r && tuse < need_e) return 1;
    if (pipe[1].a3 == r && tuse < remaining(1)) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] m_fwd(logic [4:0] r);
    if (r != 0 && pipe[1].a3 == r && remaining(1) == 0) return 2'b01;
    if (r != 0 && pipe[2].a3 == r) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [10:0] model_out();
    logic       s;
    logic [1:0] rtm;
    s = m_stall_op(rs_d, int'(tuse_rs_d)) || m_stall_op(rt_d, int'(tuse_rt_d));
    rtm = 2'b00;
    if (pipe[1].rt != 0 && pipe[2].a3 == pipe[1].rt) rtm = pipe[2].ld ? 2'b10 : 2'b01;
    return {s, m_fwd(rs_d), m_fwd(rt_d), m_fwd(pipe[0].rs), m_fwd(pipe[0].rt), rtm};
  endfunction

  function automatic ent_t bubble();
    ent_t b;
    b.a3 = '0; b.rs = '0; b.rt = '0; b.tnew = 0; b.ld = 1'b0;
    return b;
  endfunction

  function automatic logic [10:0] dut_out();
    return {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, ForwardRTM};
  endfunction

  task automatic tick();
    logic s;
    ent_t e;
    s = model_out() >> 10;
    @(posedge clk);
    if (!reset) begin
      pipe = {bubble(), bubble(), bubble()};
    end else begin
      e = bubble();
      if (!s) begin
        e.a3 = a3_d; e.rs = rs_d; e.rt = rt_d; e.tnew = int'(tnew_d); e.ld = ld_d;
      end
      pipe.push_front(e);
      void'(pipe.pop_back());
    end
    @(negedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] a3, input logic [1:0] tn, input logic ld,
                       input logic [4:0] rs, input logic [1:0] urs,
                       input logic [4:0] rt, input logic [1:0] urt);
    a3_d = a3; tnew_d = tn; ld_d = ld;
    rs_d = rs; tuse_rs_d = urs; rt_d = rt; tuse_rt_d = urt;
    #1;
  endtask

  task automatic flush();
    set_d(5'd0, 2'd0, 1'b0, 5'd0, 2'd3, 5'd0, 2'd3);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_d(5'd8, 2'd2, 1'b1, 5'd8, 2'd0, 5'd9, 2'd0);
    tick();
    set_d(5'd9, 2'd1, 1'b0, 5'd9, 2'd0, 5'd8, 2'd0);
    tick();
    reset = 1'b1;
    set_d(5'd3, 2'd1, 1'b0, 5'd8, 2'd0, 5'd9, 2'd0);
    obs = dut_out();
    n_cmp++;
    if (obs !== 11'd0) begin
      n_err++; $display("FAIL reset_outputs: got %b expected %b", obs, 11'd0);
    end
    exp_v = model_out();
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL reset_model: got %b expected %b", obs, exp_v);
    end
    tick();
  endtask

  task automatic test_alu_chain();
    flush();
    set_d(5'd8, 2'd1, 1'b0, 5'd1, 2'd1, 5'd2, 2'd1);      // addu $8
    tick();
    set_d(5'd11, 2'd1, 1'b0, 5'd8, 2'd1, 5'd3, 2'd1);     // subu rs=$8
    obs = dut_out(); exp_v = model_out();
    n_cmp++;
    if (obs !== exp_v || stall !== 1'b0) begin
      n_err++; $display("FAIL alu_no_stall: got %b expected %b", obs, exp_v);
    end
    tick();
    set_d(5'd12, 2'd1, 1'b0, 5'd8, 2'd1, 5'd0, 2'd3);     // third reader of $8
    n_cmp++;
    if (fwd_rs_e !== 2'b01) begin
      n_err++; $display("FAIL alu_fwd_e_m: got %b expected %b", fwd_rs_e, 2'b01);
    end
    obs = dut_out(); exp_v = model_out();
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL alu_model_c2: got %b expected %b", obs, exp_v);
    end
    tick();
    set_d(5'd0, 2'd0, 1'b0, 5'd0, 2'd3, 5'd0, 2'd3);
    n_cmp++;
    if (fwd_rs_e !== 2'b10) begin
      n_err++; $display("FAIL alu_fwd_e_w: got %b expected %b", fwd_rs_e, 2'b10);
    end
    tick();
    // ALU result read in D with tuse=0: one stall cycle
    set_d(5'd13, 2'd1, 1'b0, 5'd1, 2'd1, 5'd2, 2'd1);
    tick();
    set_d(5'd0, 2'd0, 1'b0, 5'd13, 2'd0, 5'd0, 2'd3);
    begin
      int cnt = 0;
      for (int i = 0; i < 5; i++) begin
        if (stall !== 1'b1) break;
        cnt++;
        tick();
      end
      n_cmp++;
      if (cnt != 1 || fwd_rs_d !== 2'b01) begin
        n_err++; $display("FAIL alu_tuse0_stall: got %0d cycles sel %b expected 1 cycles sel 01", cnt, fwd_rs_d);
      end
    end
    tick();
  endtask

  task automatic test_load_use();
    int cnt = 0;
    flush();
    set_d(5'd9, 2'd2, 1'b1, 5'd29, 2'd1, 5'd0, 2'd3);     // lw $9
    tick();
    set_d(5'd0, 2'd0, 1'b0, 5'd9, 2'd0, 5'd0, 2'd0);      // beq rs=$9
    for (int i = 0; i < 5; i++) begin
      obs = dut_out(); exp_v = model_out();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL load_use_model: got %b expected %b", obs, exp_v);
      end
      if (stall !== 1'b1) break;
      cnt++;
      tick();
    end
    n_cmp++;
    if (cnt != 2) begin
      n_err++; $display("FAIL load_use_stall_cycles: got %0d expected %0d", cnt, 2);
    end
    n_cmp++;
    if (fwd_rs_d !== 2'b10) begin
      n_err++; $display("FAIL load_use_fwd_d: got %b expected %b", fwd_rs_d, 2'b10);
    end
    tick();
  endtask

  task automatic test_store_data();
    logic [1:0] want;
    for (int k = 0; k < 2; k++) begin
      flush();
      if (k == 0) set_d(5'd10, 2'd2, 1'b1, 5'd29, 2'd1, 5'd0, 2'd3);   // lw $10
      else        set_d(5'd10, 2'd1, 1'b0, 5'd4, 2'd1, 5'd5, 2'd1);    // addu $10
      tick();
      set_d(5'd0, 2'd0, 1'b0, 5'd29, 2'd1, 5'd10, 2'd2);               // sw rt=$10
      n_cmp++;
      if (stall !== 1'b0) begin
        n_err++; $display("FAIL store_no_stall: got %b expected %b", stall, 1'b0);
      end
      tick();
      set_d(5'd0, 2'd0, 1'b0, 5'd0, 2'd3, 5'd0, 2'd3);
      tick();
      want = (k == 0) ? 2'b10 : 2'b01;
      n_cmp++;
      if (ForwardRTM !== want) begin
        n_err++; $display("FAIL store_rtm_%0d: got %b expected %b", k, ForwardRTM, want);
      end
    end
  endtask

  task automatic test_zero_reg();
    flush();
    set_d(5'd0, 2'd1, 1'b0, 5'd1, 2'd1, 5'd2, 2'd1);      // addu $0
    tick();
    set_d(5'd0, 2'd2, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0);      // lw $0 reading $0
    for (int i = 0; i < 4; i++) begin
      obs = dut_out();
      n_cmp++;
      if (obs !== 11'd0) begin
        n_err++; $display("FAIL zero_reg_c%0d: got %b expected %b", i, obs, 11'd0);
      end
      tick();
      set_d(5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0);
    end
  endtask

  task automatic test_mid_stall_reset();
    flush();
    set_d(5'd9, 2'd2, 1'b1, 5'd29, 2'd1, 5'd0, 2'd3);
    tick();
    set_d(5'd0, 2'd0, 1'b0, 5'd9, 2'd0, 5'd0, 2'd3);
    n_cmp++;
    if (stall !== 1'b1) begin
      n_err++; $display("FAIL midreset_stall_start: got %b expected %b", stall, 1'b1);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    obs = dut_out();
    n_cmp++;
    if (obs !== 11'd0) begin
      n_err++; $display("FAIL midreset_cleared: got %b expected %b", obs, 11'd0);
    end
    tick();
    set_d(5'd0, 2'd0, 1'b0, 5'd0, 2'd3, 5'd0, 2'd3);
    obs = dut_out(); exp_v = model_out();
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL midreset_after: got %b expected %b", obs, exp_v);
    end
    tick();
  endtask

  task automatic test_random();
    logic hold;
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      if (!hold) begin
        logic [1:0] tn;
        tn = 2'($urandom_range(0, 2));
        set_d(5'($urandom_range(0, 5)), tn, (tn == 2'd2) ? 1'($urandom_range(0, 1)) : 1'b0,
              5'($urandom_range(0, 5)), 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 5)), 2'($urandom_range(0, 3)));
      end else begin
        #1;
      end
      obs = dut_out(); exp_v = model_out();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL random_c%0d: got %b expected %b", i, obs, exp_v);
      end
      hold = exp_v[10] && reset;
      tick();
    end
    reset = 1'b1;
  endtask

  initial begin
    pipe = {bubble(), bubble(), bubble()};
    reset = 1'b0;
    set_d(5'd0, 2'd0, 1'b0, 5'd0, 2'd3, 5'd0, 2'd3);
    @(negedge clk);
    test_reset();
    test_alu_chain();
    test_load_use();
    test_store_data();
    test_zero_reg();
    test_mid_stall_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_hazard_fwd_ctrl.md
# mips_hazard_fwd_ctrl

Central hazard and forwarding controller for the 5-stage MIPS pipeline. It shadows each instruction's destination register, remaining result latency (Tnew) and result source as the instruction moves through E, M and W. From that state it drives the stall/bubble signals and the forwarding selects consumed by the D, E and M operand multiplexers. It is the producer side of the `ForwardRTM` encoding used by the MEM write-data mux.

## Interface
Parameters:
- none (fixed 32-register MIPS file; register 0 is never forwarded).

Ports:
- `clk` in 1: pipeline clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `rs_d` in 5: rs field of the instruction in D.
- `rt_d` in 5: rt field of the instruction in D.
- `tuse_rs_d` in 2: cycles until D instruction needs rs (0 = in D, 1 = in E, 2 = in M, 3 = unused).
- `tuse_rt_d` in 2: same encoding, for rt.
- `a3_d` in 5: destination register of the D instruction; 0 if it does not write.
- `tnew_d` in 2: cycles after entering E until result exists (0 = link PC, 1 = ALU, 2 = load).
- `ld_d` in 1: 1 if the D instruction's result comes from data memory.
- `stall` out 1: freeze PC and the IF/ID register; insert a bubble into ID/EX.
- `fwd_rs_d` out 2: D-stage rs select: 00 regfile, 01 M-stage result, 10 W-stage result.
- `fwd_rt_d` out 2: D-stage rt select, same encoding as `fwd_rs_d`.
- `fwd_rs_e` out 2: E-stage rs select: 00 pipeline value, 01 M-stage result, 10 W-stage result.
- `fwd_rt_e` out 2: E-stage rt select, same encoding as `fwd_rs_e`.
- `ForwardRTM` out 2: M-stage write-data select: 00 `WriteData_M`, 01 `result_W` (W ALU/link result), 10 `result_WD` (W load data). 11 is never driven.

## Operation
State per stage:
- E holds `a3`, `tnew`, `ld`, `rs`, `rt`.
- M holds `a3`, `tnew`, `ld`, `rt`.
- W holds `a3` and `ld`; its `tnew` is always 0.

Advance on every clock edge:
- E ← D fields, or a bubble when `stall`=1. A bubble has all fields 0.
- M ← E with `tnew` decremented, saturating at 0.
- W ← M.
- M and W always advance; only D/F freeze.

Match rule: stage X matches register r iff `a3_X == r` and `r != 0`.

Stall (evaluated separately for rs and rt, then ORed):
- Assert if E matches and `tuse < max(tnew_e, 1)`. There is no E→D path, so an E link result still stalls a `tuse`=0 reader for one cycle.
- Assert if M matches and `tuse < tnew_m`.
- `tuse`=3 never stalls.

Forward select, nearest stage first:
- D selects: M match with `tnew_m`=0 → 01; else W match → 10; else 00.
- E selects use E's stored `rs`/`rt`: M match with `tnew_m`=0 → 01; else W match → 10; else 00.
- `ForwardRTM` uses M's stored `rt`: W match → (`ld_w` ? 10 : 01); else 00.

Forwarding from M never applies to a load in M, because that entry has `tnew_m` ≥ 1 and the stall logic already covers it.

## Timing
- Reset: when `reset`=0 at a rising edge, all stage entries are cleared. In the following cycle every output is 0 (`stall`=0, all selects 00).
- Reset takes priority over stall and advance, including mid-stall. Instructions in flight are discarded.
- Outputs are purely combinational from stage state and D inputs, with zero latency in the same cycle.
- A load-use with `tuse`=0 gives 2 stall cycles. A load-use with `tuse`=1 gives 1 stall cycle. An ALU result with `tuse`=0 gives 1 stall cycle. All other RAW cases give no stall.
- A stall repeats each cycle until its condition clears. D inputs are held stable by the frozen IF/ID register.
- When both M and W write the same register, M wins.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with arbitrary D inputs → `stall`=0 and all selects 00 in the cycle after release.
- ALU chain: `addu $8` (`tnew`=1), then `subu` with rs=$8 and `tuse_rs`=1 → second instruction in E sees `fwd_rs_e`=01. One cycle later, a third reader of $8 in E sees 10.
- Load-use: `lw $9` (`tnew`=2, `ld`=1), then `beq` with rs=$9 and `tuse_rs`=0 → `stall`=1 for 2 cycles, then `fwd_rs_d`=10.
- Store data: `lw $10`, then `sw` with rt=$10 → no stall. When the `sw` is in M, `ForwardRTM`=10. Repeat with `addu $10` as producer → `ForwardRTM`=01.
- $0 writes: `addu $0` followed by readers of $0 → never stalls, and all selects stay 00.
- Mid-stall reset: start a load-use stall, assert `reset`=0 in the first stall cycle → next cycle `stall`=0 and the E, M and W entries are empty.
